// File: rtl/ram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ram_rr_arbiter
//
// Two-requester round-robin arbiter in front of one single-port synchronous
// RAM. One access is granted per cycle. The RAM registers its read address,
// so read data arrives one cycle after the grant and is steered back to the
// requester that issued the read. Each requester's rdata holds its last read
// value between reads.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req0/we0/addr0/wdata0   requester 0 request, write flag, address, data
//   gnt0                    requester 0 access accepted this cycle (comb.)
//   rvalid0/rdata0          requester 0 read-data valid pulse / read data
//   req1 ... rdata1         same for requester 1
//   ram_addr/ram_data/ram_we  RAM address, write data, write enable
//   ram_q                   RAM read data for the address registered last edge
// ---------------------------------------------------------------------------
module ram_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,

    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    logic                  last_gnt;   // index of the most recent winner
    logic                  rd_pend;    // a read was granted last cycle
    logic                  pend_sel;   // which requester that read belongs to
    logic [DATA_WIDTH-1:0] hold0;
    logic [DATA_WIDTH-1:0] hold1;

    logic                  rd0_go;
    logic                  rd1_go;

    // Grant: under contention the requester that did not win last time wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (req0 && req1) begin
                if (last_gnt) gnt0 = 1'b1;
                else          gnt1 = 1'b1;
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // RAM port mux; requester 0 fields are parked on the bus when idle.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = addr0;
        ram_data = wdata0;
        if (gnt0) begin
            ram_we   = we0;
            ram_addr = addr0;
            ram_data = wdata0;
        end else if (gnt1) begin
            ram_we   = we1;
            ram_addr = addr1;
            ram_data = wdata1;
        end
    end

    assign rd0_go = gnt0 && !we0;
    assign rd1_go = gnt1 && !we1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
            rd_pend  <= 1'b0;
            pend_sel <= 1'b0;
            hold0    <= '0;
            hold1    <= '0;
        end else begin
            if (gnt0)      last_gnt <= 1'b0;
            else if (gnt1) last_gnt <= 1'b1;

            rd_pend <= rd0_go || rd1_go;
            if (rd0_go)      pend_sel <= 1'b0;
            else if (rd1_go) pend_sel <= 1'b1;

            // Capture the returning word so it can be presented between reads.
            if (rvalid0) hold0 <= ram_q;
            if (rvalid1) hold1 <= ram_q;
        end
    end

    // One shared pending-read flag, split by the recorded owner.
    always_comb begin
        rvalid0 = rd_pend && !pend_sel;
        rvalid1 = rd_pend &&  pend_sel;
        rdata0  = rvalid0 ? ram_q : hold0;
        rdata1  = rvalid1 ? ram_q : hold1;
    end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_rr_arbiter
//
// Bench for ram_rr_arbiter. Attaches a behavioural single-port RAM with a
// registered read address, runs a directed table of cycles, a reset-during-
// read sequence, and a randomized phase checked against a reference model.
// ---------------------------------------------------------------------------
module tb_ram_rr_arbiter;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .ram_q(ram_q)
    );

    function automatic logic [DW-1:0] init_val(int unsigned i);
        case (i)
            1:       return 8'h11;
            2:       return 8'h22;
            3:       return 8'hA5;
            default: return 8'(i * 8 + 3);
        endcase
    endfunction

    // Behavioural RAM: write commits at the edge, read address registered.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ram_addr_q;
    bit            ram_loaded = 1'b0;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
            ram_loaded <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_data;
        end
        ram_addr_q <= ram_addr;
    end
    assign ram_q = mem[ram_addr_q];

    // Reference model: who wins, what the memory holds, what each requester
    // should see on its read port.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_loaded = 1'b0;
    int            m_last;
    bit            m_rv0, m_rv1;
    logic [DW-1:0] m_rd0, m_rd1;

    function automatic int mgrant();
        if (rst_n !== 1'b1) return -1;
        if (req0 && req1)   return (m_last == 1) ? 0 : 1;
        if (req0)           return 0;
        if (req1)           return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!m_loaded) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] <= init_val(i);
            m_loaded <= 1'b1;
        end
        if (!rst_n) begin
            m_last <= 1;
            m_rv0  <= 1'b0;
            m_rv1  <= 1'b0;
            m_rd0  <= '0;
            m_rd1  <= '0;
        end else begin
            m_rv0 <= 1'b0;
            m_rv1 <= 1'b0;
            case (mgrant())
                0: begin
                    m_last <= 0;
                    if (we0) ref_mem[addr0] <= wdata0;
                    else begin m_rv0 <= 1'b1; m_rd0 <= ref_mem[addr0]; end
                end
                1: begin
                    m_last <= 1;
                    if (we1) ref_mem[addr1] <= wdata1;
                    else begin m_rv1 <= 1'b1; m_rd1 <= ref_mem[addr1]; end
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int            g;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        g = mgrant();
        e_we = 1'b0; e_addr = addr0; e_data = wdata0;
        if (g == 0)      begin e_we = we0; e_addr = addr0; e_data = wdata0; end
        else if (g == 1) begin e_we = we1; e_addr = addr1; e_data = wdata1; end
        chk("m_gnt0",     32'(gnt0),     32'(g == 0));
        chk("m_gnt1",     32'(gnt1),     32'(g == 1));
        chk("m_ram_we",   32'(ram_we),   32'(e_we));
        chk("m_ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("m_ram_data", 32'(ram_data), 32'(e_data));
        chk("m_rvalid0",  32'(rvalid0),  32'(m_rv0));
        chk("m_rvalid1",  32'(rvalid1),  32'(m_rv1));
        chk("m_rdata0",   32'(rdata0),   32'(m_rd0));
        chk("m_rdata1",   32'(rdata1),   32'(m_rd1));
    endtask

    typedef struct {
        logic          r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic          r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic          g0, g1;
        logic          rv0; logic [DW-1:0] rd0;
        logic          rv1; logic [DW-1:0] rd1;
        logic          rwe; logic [AW-1:0] raddr; logic [DW-1:0] rdat;
    } vec_t;

    vec_t tbl [18];

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //        r0 w0 a0  d0     r1 w1 a1  d1     g0 g1 rv0 rd0    rv1 rd1    rwe ra  rdat
        tbl[0]  = '{1, 0, 3, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0, 3, 8'h00};
        tbl[1]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 8'hA5, 0, 8'h00, 0, 0, 8'h00};
        tbl[2]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 8'hA5, 0, 8'h00, 0, 0, 8'h00};
        tbl[3]  = '{1, 1, 7, 8'h3C, 0, 0, 0, 8'h00, 1, 0, 0, 8'hA5, 0, 8'h00, 1, 7, 8'h3C};
        tbl[4]  = '{1, 0, 7, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 8'hA5, 0, 8'h00, 0, 7, 8'h00};
        tbl[5]  = '{0, 0, 0, 8'h00, 1, 0, 5, 8'h00, 0, 1, 1, 8'h3C, 0, 8'h00, 0, 5, 8'h00};
        tbl[6]  = '{1, 0, 1, 8'h00, 1, 0, 2, 8'h00, 1, 0, 0, 8'h3C, 1, 8'h2B, 0, 1, 8'h00};
        tbl[7]  = '{1, 0, 1, 8'h00, 1, 0, 2, 8'h00, 0, 1, 1, 8'h11, 0, 8'h2B, 0, 2, 8'h00};
        tbl[8]  = '{1, 0, 1, 8'h00, 1, 0, 2, 8'h00, 1, 0, 0, 8'h11, 1, 8'h22, 0, 1, 8'h00};
        tbl[9]  = '{1, 0, 1, 8'h00, 1, 0, 2, 8'h00, 0, 1, 1, 8'h11, 0, 8'h22, 0, 2, 8'h00};
        tbl[10] = '{0, 0, 0, 8'h00, 1, 1, 4, 8'h99, 0, 1, 0, 8'h11, 1, 8'h22, 1, 4, 8'h99};
        tbl[11] = '{1, 0, 4, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 8'h11, 0, 8'h22, 0, 4, 8'h00};
        tbl[12] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 8'h99, 0, 8'h22, 0, 0, 8'h00};
        for (int i = 13; i < 18; i++)
            tbl[i] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 8'h99, 0, 8'h22, 0, 0, 8'h00};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_rdata0",  32'(rdata0),  32'd0);
        chk("rst_rdata1",  32'(rdata1),  32'd0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                  tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            @(negedge clk);
            chk($sformatf("t%0d_gnt0", i),     32'(gnt0),     32'(tbl[i].g0));
            chk($sformatf("t%0d_gnt1", i),     32'(gnt1),     32'(tbl[i].g1));
            chk($sformatf("t%0d_rvalid0", i),  32'(rvalid0),  32'(tbl[i].rv0));
            chk($sformatf("t%0d_rdata0", i),   32'(rdata0),   32'(tbl[i].rd0));
            chk($sformatf("t%0d_rvalid1", i),  32'(rvalid1),  32'(tbl[i].rv1));
            chk($sformatf("t%0d_rdata1", i),   32'(rdata1),   32'(tbl[i].rd1));
            chk($sformatf("t%0d_ram_we", i),   32'(ram_we),   32'(tbl[i].rwe));
            chk($sformatf("t%0d_ram_addr", i), 32'(ram_addr), 32'(tbl[i].raddr));
            chk($sformatf("t%0d_ram_data", i), 32'(ram_data), 32'(tbl[i].rdat));
            @(posedge clk);
            #1;
        end

        // Reset while requester 1's read data is being returned
        drive(0, 0, 0, 0, 1, 0, 2, 0);
        @(negedge clk);
        chk("rr_gnt1", 32'(gnt1), 32'd1);
        @(posedge clk);
        #1;
        chk("rr_rvalid1_pre", 32'(rvalid1), 32'd1);
        chk("rr_rdata1_pre",  32'(rdata1),  32'h22);
        #1;
        rst_n = 1'b0;
        drive(1, 1, 9, 8'h55, 1, 1, 10, 8'h66);
        #1;
        chk("rr_gnt0",    32'(gnt0),    32'd0);
        chk("rr_gnt1_in", 32'(gnt1),    32'd0);
        chk("rr_ram_we",  32'(ram_we),  32'd0);
        chk("rr_rvalid1", 32'(rvalid1), 32'd0);
        chk("rr_rdata1",  32'(rdata1),  32'd0);
        chk("rr_rdata0",  32'(rdata0),  32'd0);
        @(negedge clk);
        check_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 0, 3, 0, 1, 0, 1, 0);
        @(negedge clk);
        chk("rr_post_gnt0", 32'(gnt0), 32'd1);
        chk("rr_post_addr", 32'(ram_addr), 32'd3);
        check_model();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rr_post_gnt1",    32'(gnt1),    32'd1);
        chk("rr_post_rvalid0", 32'(rvalid0), 32'd1);
        chk("rr_post_rdata0",  32'(rdata0),  32'hA5);
        check_model();
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  AW'($urandom), DW'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  AW'($urandom), DW'($urandom));
            if (n % 50 == 49) drive(0, 0, AW'($urandom), DW'($urandom), 0, 0, 0, 0);
            @(negedge clk);
            check_model();
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Two-requester round-robin arbiter sharing one single-port synchronous RAM.
- The RAM has a registered read address: read data is valid the cycle after the address is presented, and writes commit at the clock edge.
- One access is granted per cycle.
- Read data returns to the granted requester with a valid pulse and is held between reads.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 5, RAM address width (depth 2**ADDR_WIDTH).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 access request; held until gnt0.
- we0  input  1  requester 0 write (1) / read (0).
- addr0  input  ADDR_WIDTH  requester 0 address.
- wdata0  input  DATA_WIDTH  requester 0 write data.
- gnt0  output  1  access accepted this cycle (combinational).
- rvalid0  output  1  read data valid for requester 0.
- rdata0  output  DATA_WIDTH  read data / held last read for requester 0.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as requester 0, for requester 1.
- ram_addr  output  ADDR_WIDTH  address to RAM.
- ram_data  output  DATA_WIDTH  write data to RAM.
- ram_we  output  1  RAM write enable.
- ram_q  input  DATA_WIDTH  RAM read data (reflects the address registered last edge).

Behaviour:
- Reset (rst_n low, asynchronous), all registers cleared:
  - last_gnt=1, so requester 0 wins the first contention.
  - rvalid0/1 regs = 0.
  - Hold registers hold0/hold1 = 0.
  - pend_sel = 0.
- While rst_n is low: gnt0=gnt1=0 and ram_we=0, combinationally.
- Grant (combinational, rst_n high):
  - Only req0: gnt0=1.
  - Only req1: gnt1=1.
  - Both: grant the requester != last_gnt.
  - Neither: no grant.
  - gnt0 and gnt1 are never both 1.
- RAM mux:
  - With a grant: ram_addr, ram_data and ram_we = granted requester's addr, wdata and we.
  - With no grant: ram_we=0, ram_addr=addr0, ram_data=wdata0.
- On a clock edge with any grant: last_gnt <= index of the granted requester. With no grant, last_gnt is unchanged.
- Read pipeline:
  - A granted read (we=0) at cycle T sets rvalidX=1 at T+1 for exactly one cycle, unless it is re-granted.
  - pend_sel records X.
  - A granted write produces no rvalid.
- Read data:
  - In a cycle where rvalidX=1: rdataX = ram_q.
  - At that cycle's end edge: holdX <= ram_q.
  - Otherwise: rdataX = holdX.
  - The other requester's rdata is unaffected.
- Latency:
  - Read: 1 cycle from grant to rvalid.
  - Write: committed at the grant edge.
- Throughput: back-to-back grants every cycle are allowed, including consecutive reads by the same requester, which give rvalid high on consecutive cycles with a new ram_q each cycle.
- Write then read of the same address in the next cycle returns the new data.
- Fairness: under continuous contention, grants alternate 0,1,0,1. Maximum wait is 1 cycle.
- A requester dropping req without a grant is legal; no state changes.
- Reset asserted mid-read: the pending rvalid is lost (cleared) and the hold registers are zeroed. After release, arbitration restarts with requester 0 priority.
- Address and data widths pass through unmodified; no arithmetic.

Test Plan:
- Reset release, req0 read addr 3 (RAM[3]=0xA5) -> gnt0 same cycle; rvalid0=1, rdata0=0xA5 next cycle; rdata0 stays 0xA5 afterwards; rvalid1 stays 0.
- req0 write addr 7 data 0x3C, then req0 read addr 7 the next cycle -> rvalid0 with rdata0=0x3C two cycles after the write grant.
- req0 and req1 both hold reads (addr 1=0x11, addr 2=0x22) continuously for 4 cycles -> gnt order 0,1,0,1. rvalid0/rdata0=0x11 and rvalid1/rdata1=0x22 alternate, each 1 cycle after its grant.
- req1 alone writes addr 4=0x99 while req0 idle -> gnt1=1, ram_we=1, ram_addr=4, ram_data=0x99; a subsequent read of addr 4 by req0 returns 0x99.
- Read granted to req1, rst_n pulsed low before the next edge -> rvalid1=0, rdata1=0, gnt/ram_we 0 during reset. After release, simultaneous reqs grant requester 0 first.
- Idle (no reqs) for 5 cycles after reads -> ram_we=0, no rvalid, rdata0/rdata1 hold their last values.
